// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared word type and loader state encoding.
package imem_loader_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR} state_t;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs payload bytes little-endian into 32-bit words, one write strobe per word.
import imem_loader_pkg::*;
module word_assembler (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       en,
   input  logic [7:0] data,
   output logic [1:0] idx,
   output logic       wr_en,
   output word_t      wr_data
);
   logic [23:0] acc;
   // Shifting in from the top leaves byte 0 in the low lane after three bytes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         acc     <= '0;
         wr_en   <= 1'b0;
         wr_data <= '0;
      end else begin
         wr_en <= 1'b0;
         if (clear) begin
            idx <= '0;
         end else if (en) begin
            idx <= idx + 2'd1;
            acc <= {data, acc[23:8]};
            if (idx == 2'd3) begin
               wr_en   <= 1'b1;
               wr_data <= {data, acc};
            end
         end
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length/payload/checksum byte frame and writes it into instruction memory.
import imem_loader_pkg::*;
module imem_loader #(
   parameter int program_instructions = 256,
   parameter int ADDR_W = $clog2(program_instructions)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_write_enable,
   output logic [ADDR_W-1:0] imem_write_addr,
   output logic [31:0]       imem_write_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);
   state_t      state;
   logic [15:0] len;
   logic [16:0] wcnt;
   logic [7:0]  csum;
   logic [1:0]  idx;
   logic [15:0] n;
   logic        restart;
   assign n        = {rx_data, len[7:0]};
   assign restart  = start && (state inside {IDLE, DONE, ERROR});
   assign rx_ready = state inside {LEN_LO, LEN_HI, PAYLOAD, CHECK};
   assign cpu_hold = state != DONE;
   assign done     = state == DONE;
   assign error    = state == ERROR;
   word_assembler u_asm (
      .clock  (clock),
      .reset  (reset),
      .clear  (restart),
      .en     (rx_valid && state == PAYLOAD),
      .data   (rx_data),
      .idx    (idx),
      .wr_en  (imem_write_enable),
      .wr_data(imem_write_data)
   );
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         len             <= '0;
         wcnt            <= '0;
         csum            <= '0;
         imem_write_addr <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: if (start) begin
               state           <= LEN_LO;
               wcnt            <= '0;
               csum            <= '0;
               imem_write_addr <= '0;
            end
            LEN_LO: if (rx_valid) begin
               len[7:0] <= rx_data;
               state    <= LEN_HI;
            end
            LEN_HI: if (rx_valid) begin
               len[15:8] <= rx_data;
               state     <= n == 16'd0 ? CHECK : int'(n) > program_instructions ? ERROR : PAYLOAD;
            end
            PAYLOAD: if (rx_valid) begin
               csum <= csum ^ rx_data;
               // The address is latched with the 4th byte so it lines up with the write strobe.
               if (idx == 2'd3) begin
                  imem_write_addr <= wcnt[ADDR_W-1:0];
                  wcnt            <= wcnt + 17'd1;
                  if (wcnt + 17'd1 == {1'b0, len}) state <= CHECK;
               end
            end
            CHECK: if (rx_valid) state <= rx_data == csum ? DONE : ERROR;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frame loads with hand-computed writes and status checks.
module tb_imem_loader;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready, imem_write_enable, cpu_hold, done, error;
   logic [7:0]  imem_write_addr;
   logic [31:0] imem_write_data;
   int passed = 0, total = 0, fails = 0;
   logic [31:0] log_a[$];
   logic [31:0] log_d[$];
   logic [7:0]  pay[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
   localparam logic [7:0] GOOD_CSUM = 8'hC0;

   imem_loader #(.program_instructions(256)) dut (
      .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_write_enable(imem_write_enable), .imem_write_addr(imem_write_addr),
      .imem_write_data(imem_write_data), .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (imem_write_enable) begin
      log_a.push_back(32'(imem_write_addr));
      log_d.push_back(imem_write_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      start = 1'b0;
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clock);
      #1 rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic send_frame_a(input logic [7:0] cs);
      send_byte(8'h02);
      send_byte(8'h00);
      for (int i = 0; i < 8; i++) send_byte(pay[i]);
      send_byte(cs);
      @(negedge clock);
   endtask

   task automatic check_writes_a(input string tag);
      check({tag, "_nwr"}, log_a.size(), 2);
      if (log_a.size() == 2) begin
         check({tag, "_a0"}, log_a[0], 32'd0);
         check({tag, "_d0"}, log_d[0], 32'h00500013);
         check({tag, "_a1"}, log_a[1], 32'd1);
         check({tag, "_d1"}, log_d[1], 32'h00100093);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rdy"}, rx_ready, 0);
      check({tag, "_we"}, imem_write_enable, 0);
      check({tag, "_addr"}, imem_write_addr, 0);
      check({tag, "_data"}, imem_write_data, 0);
      check({tag, "_hold"}, cpu_hold, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, error, 0);
   endtask

   initial begin
      #1 check_reset_vals("rst");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      send_byte(8'h55);
      repeat (2) @(negedge clock);
      check("idle_rdy", rx_ready, 0);
      check("idle_hold", cpu_hold, 1);
      check("idle_nwr", log_a.size(), 0);

      // Good load, with explicit write-strobe timing on the first word
      log_a.delete(); log_d.delete();
      pulse_start();
      check("lenlo_rdy", rx_ready, 1);
      send_byte(8'h02);
      send_byte(8'h00);
      for (int i = 0; i < 4; i++) send_byte(pay[i]);
      @(negedge clock);
      check("t1_we", imem_write_enable, 1);
      check("t1_addr", imem_write_addr, 0);
      check("t1_data", imem_write_data, 32'h00500013);
      @(negedge clock);
      check("t2_we", imem_write_enable, 0);
      for (int i = 4; i < 8; i++) send_byte(pay[i]);
      send_byte(GOOD_CSUM);
      @(negedge clock);
      check_writes_a("good");
      check("good_done", done, 1);
      check("good_hold", cpu_hold, 0);
      check("good_err", error, 0);
      check("good_rdy", rx_ready, 0);

      // Bad checksum keeps the writes already issued
      log_a.delete(); log_d.delete();
      pulse_start();
      check("restart_done", done, 0);
      check("restart_hold", cpu_hold, 1);
      send_frame_a(8'h31);
      check_writes_a("bad");
      check("bad_err", error, 1);
      check("bad_hold", cpu_hold, 1);
      check("bad_done", done, 0);

      // N=257 exceeds depth
      log_a.delete(); log_d.delete();
      pulse_start();
      check("big_err_clr", error, 0);
      send_byte(8'h01);
      send_byte(8'h01);
      @(negedge clock);
      check("big_err", error, 1);
      check("big_rdy", rx_ready, 0);
      for (int i = 0; i < 4; i++) send_byte(pay[i]);
      @(negedge clock);
      check("big_nwr", log_a.size(), 0);
      check("big_err_hold", error, 1);

      // N=0 with checksum 0
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clock);
      check("zero_done", done, 1);
      check("zero_nwr", log_a.size(), 0);

      // Random valid gaps and stray start pulses
      log_a.delete(); log_d.delete();
      pulse_start();
      for (int i = 0; i < 11; i++) begin
         logic [7:0] b;
         b = i == 0 ? 8'h02 : i == 1 ? 8'h00 : i == 10 ? GOOD_CSUM : pay[i-2];
         repeat ($urandom_range(0, 3)) begin
            @(negedge clock);
            rx_data = 8'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         send_byte(b);
      end
      @(negedge clock);
      check_writes_a("gap");
      check("gap_done", done, 1);

      // Asynchronous reset mid-payload, then a clean reload
      log_a.delete(); log_d.delete();
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      for (int i = 0; i < 3; i++) send_byte(pay[i]);
      #2 reset = 1'b0;
      #1 check_reset_vals("mid");
      @(negedge clock);
      reset = 1'b1;
      send_byte(pay[3]);
      repeat (2) @(negedge clock);
      check_reset_vals("post");
      check("mid_nwr", log_a.size(), 0);
      pulse_start();
      send_frame_a(GOOD_CSUM);
      check_writes_a("reload");
      check("reload_done", done, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
